// File: rtl/sd_fifo_packer_if.sv
// ---------------------------------------------------------------------------
// sd_fifo_packer_if
//
// Purpose:
//   Bundles the two srdy/drdy channels of the width upsizer. The narrow
//   consumer side is c_* and the wide producer side is p_*.
//
// Parameters:
//   width : narrow word width in bits
//   ratio : narrow words per wide word (power of 2, >= 2)
//
// Signals:
//   c_srdy / c_drdy / c_data / c_eop : narrow words from the upstream FIFO
//   p_srdy / p_drdy / p_data / p_eop / p_cnt : packed wide words downstream
//
// Modports:
//   slave  : the packer itself (sinks c_*, sources p_*)
//   master : the surrounding environment (sources c_*, sinks p_*)
// ---------------------------------------------------------------------------
interface sd_fifo_packer_if #(
   parameter int width = 8,
   parameter int ratio = 4
);

   localparam int cnt_w  = $clog2(ratio) + 1;
   localparam int wide_w = width * ratio;

   // narrow (consumer) channel
   logic              c_srdy;
   logic              c_drdy;
   logic [width-1:0]  c_data;
   logic              c_eop;

   // wide (producer) channel
   logic              p_srdy;
   logic              p_drdy;
   logic [wide_w-1:0] p_data;
   logic              p_eop;
   logic [cnt_w-1:0]  p_cnt;

   modport slave (
      input  c_srdy,
      output c_drdy,
      input  c_data,
      input  c_eop,
      output p_srdy,
      input  p_drdy,
      output p_data,
      output p_eop,
      output p_cnt
   );

   modport master (
      output c_srdy,
      input  c_drdy,
      output c_data,
      output c_eop,
      input  p_srdy,
      output p_drdy,
      input  p_data,
      input  p_eop,
      input  p_cnt
   );

endinterface : sd_fifo_packer_if

// File: rtl/sd_fifo_packer.sv
// ---------------------------------------------------------------------------
// sd_fifo_packer
//
// Purpose:
//   Srdy/drdy width upsizer placed directly after the small FIFO, in its
//   read clock domain. Packs `ratio` consecutive narrow words into one wide
//   word, lane 0 first. A narrow word flagged with c_eop flushes a partially
//   filled wide word early, and p_cnt reports how many lanes are valid.
//
// Parameters:
//   width : narrow input word width in bits (default 8)
//   ratio : narrow words per wide word; power of 2, minimum 2 (default 4)
//
// Ports:
//   clk   : block clock, rising edge
//   reset : synchronous active-low reset
//   io    : sd_fifo_packer_if.slave
//           c_srdy/c_drdy/c_data/c_eop        narrow input channel
//           p_srdy/p_drdy/p_data/p_eop/p_cnt  wide output channel
//
// Throughput:
//   c_drdy = !p_srdy | p_drdy, so one narrow word per cycle is sustained
//   while the downstream keeps p_drdy high. The combinational p_drdy ->
//   c_drdy path is deliberate; it removes a bubble when a completed word
//   leaves in the same cycle that the next one completes.
// ---------------------------------------------------------------------------
module sd_fifo_packer #(
   parameter int width = 8,
   parameter int ratio = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   sd_fifo_packer_if.slave      io
);

   localparam int lane_w = $clog2(ratio);
   localparam int cnt_w  = lane_w + 1;
   localparam int wide_w = width * ratio;

   localparam logic [lane_w-1:0] last_lane = lane_w'(ratio - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [wide_w-1:0] acc_data;
   logic [lane_w-1:0] acc_cnt;

   logic              out_srdy;
   logic [wide_w-1:0] out_data;
   logic              out_eop;
   logic [cnt_w-1:0]  out_cnt;

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   logic c_drdy;
   logic c_xfer;
   logic p_xfer;
   logic complete;

   // The output register can take a new word when it is empty or is
   // being emptied this very cycle.
   assign c_drdy   = !out_srdy | io.p_drdy;
   assign c_xfer   = io.c_srdy & c_drdy;
   assign p_xfer   = out_srdy & io.p_drdy;

   // c_eop only matters on an accepted word, so it is qualified by c_xfer.
   assign complete = c_xfer & ((acc_cnt == last_lane) | io.c_eop);

   // ------------------------------------------------------------------
   // Lane merge: current word into lane acc_cnt, lanes above it zeroed.
   // ------------------------------------------------------------------
   logic [wide_w-1:0] merged;
   logic [cnt_w-1:0]  flush_cnt;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      merged = acc_data;
      for (int i = 0; i < ratio; i++) begin
         if (i == int'(acc_cnt)) begin
            merged[i*width +: width] = io.c_data;
         end else if (i > int'(acc_cnt)) begin
            // Already zero after a flush or reset; forced here so a flushed
            // word can never carry stale lanes.
            merged[i*width +: width] = '0;
         end
      end
   end

   assign flush_cnt = cnt_w'(acc_cnt) + cnt_w'(1);

   // ------------------------------------------------------------------
   // Accumulator
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         // NOTE: acc_data is a plain register bank, not a RAM, so it is reset to keep discarded partial words from leaking into later flushes.
         acc_data <= '0;
         acc_cnt  <= '0;
      end else if (c_xfer) begin
         if (complete) begin
            acc_data <= '0;
            acc_cnt  <= '0;
         end else begin
            acc_data <= merged;
            acc_cnt  <= acc_cnt + lane_w'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   // A completing input always has c_drdy=1, which means the register is
   // either empty or emptying this cycle, so loading never overwrites an
   // untransferred word. While stalled (p_srdy=1, p_drdy=0) nothing is
   // accepted and the register holds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_srdy <= 1'b0;
         out_data <= '0;
         out_eop  <= 1'b0;
         out_cnt  <= '0;
      end else if (complete) begin
         out_srdy <= 1'b1;
         out_data <= merged;
         out_eop  <= io.c_eop;
         out_cnt  <= flush_cnt;
      end else if (p_xfer) begin
         out_srdy <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Port drive
   // ------------------------------------------------------------------
   assign io.c_drdy = c_drdy;
   assign io.p_srdy = out_srdy;
   assign io.p_data = out_data;
   assign io.p_eop  = out_eop;
   assign io.p_cnt  = out_cnt;

endmodule : sd_fifo_packer

// File: doc/sd_fifo_packer.md
Name: sd_fifo_packer

Overview:
- Srdy/drdy width upsizer that sits directly downstream of the small FIFO, on its producer-side (read) clock domain.
- Accepts narrow words from the FIFO output and packs `ratio` consecutive words into one wide output word.
- A word flagged end-of-packet flushes a partial wide word early, tagged with a valid-lane count.
- Feeds wide datapaths such as memory writers or wide FIFOs.

Parameters:
- width, 8: narrow input word width in bits.
- ratio, 4: narrow words per wide output word; power of 2, minimum 2.

Ports:
- clk  input  1  block clock; all logic sampled on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- c_srdy  input  1  narrow word valid from upstream FIFO.
- c_drdy  output  1  block accepts narrow word this cycle.
- c_data  input  width  narrow word.
- c_eop  input  1  current narrow word is last of packet; qualified by c_srdy.
- p_srdy  output  1  wide word valid.
- p_drdy  input  1  downstream accepts wide word.
- p_data  output  width*ratio  packed wide word; lane 0 = bits [width-1:0].
- p_eop  output  1  wide word contains end of packet.
- p_cnt  output  $clog2(ratio)+1  number of valid lanes in p_data, 1..ratio.

Behaviour:
- Transfer rules:
  - Input transfer occurs when c_srdy & c_drdy.
  - Output transfer occurs when p_srdy & p_drdy.
- Internal state:
  - Accumulator: acc_data (width*ratio bits), acc_cnt ($clog2(ratio) bits).
  - Output register: p_data, p_eop, p_cnt, p_srdy.
- Reset (reset==0 at clk edge):
  - acc_cnt=0, acc_data=0.
  - p_srdy=0, p_data=0, p_eop=0, p_cnt=0.
  - Any partial word is discarded.
  - c_drdy is combinational and not gated by reset.
- c_drdy = !p_srdy | p_drdy.
  - Combinational path from p_drdy to c_drdy is intentional.
  - Full rate of 1 narrow word/cycle is sustained while p_drdy=1.
- Lane placement: the accepted word is written to lane acc_cnt of acc_data; lanes fill in arrival order, lane 0 first.
- Completion: an input transfer completes a wide word when acc_cnt==ratio-1 or c_eop==1. On completion, in the same cycle:
  - Output register loads acc_data merged with the current word.
  - Lanes above the current lane are forced to 0.
  - p_cnt = acc_cnt+1.
  - p_eop = c_eop.
  - p_srdy = 1.
  - acc_cnt returns to 0 and acc_data clears to 0.
- Non-completing transfer: acc_cnt increments by 1; the output register is untouched.
- Latency: a wide word is presented on p_srdy the cycle after the completing narrow word is accepted.
- Output register update:
  - Output transfer with no completing input that cycle: p_srdy clears to 0 next cycle.
  - Output transfer and completing input in the same cycle: the new word loads and p_srdy stays 1 (back-to-back).
  - p_srdy=1 & p_drdy=0: p_data/p_eop/p_cnt hold stable; c_drdy=0, so no input is accepted.
- c_eop on lane ratio-1: p_cnt=ratio, p_eop=1.
- c_eop on lane 0: p_cnt=1, with lanes 1..ratio-1 zero.
- c_eop ignored when c_srdy=0.
- No timeout flush: a partial word without eop stays in the accumulator indefinitely.
- Mid-operation reset: accumulator and output register are cleared.
  - First word after reset lands in lane 0.
- No data reordering, duplication or loss outside reset.

Test Plan:
- width=8, ratio=4, p_drdy=1; send 0x11,0x22,0x33,0x44 on consecutive cycles, no eop.
  - Required: one cycle after 0x44 is accepted, p_srdy=1, p_data=0x44332211, p_cnt=4, p_eop=0.
- Send 0xA1,0xA2 with eop on 0xA2.
  - Required: p_data=0x0000A2A1, p_cnt=2, p_eop=1; next word then starts at lane 0.
- Send 0x5A with eop at lane 0.
  - Required: p_data=0x0000005A, p_cnt=1, p_eop=1.
- Continuous 16-word stream 0x00..0x0F, p_drdy=1.
  - Required: 4 wide words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - Required: c_drdy never low; wide words arrive on cycles 4,8,12,16 after the first accept.
- Backpressure: complete a wide word, hold p_drdy=0 for 5 cycles with c_srdy=1.
  - Required: c_drdy=0 and p_data stable throughout.
  - Required: on release, the pending word transfers and input resumes the same cycle with no loss.
- Accept 0x11,0x22, then drive reset=0 for 1 cycle, then send 0x33..0x36.
  - Required: the wide word is 0x36353433; 0x11 and 0x22 never appear.
  - Required: p_srdy=0 during the reset cycle.
